// File: rtl/speaker_arbiter_pkg.sv
// speaker_pkg: shared types and the fixed beep-pattern table for the
// speaker arbiter.
//   state_t   - arbiter sequencing states
//   pattern_t - one beep pattern: tone half-period (clk cycles), beep count,
//               on/off durations in ticks
//   PATTERNS  - packed table indexed by requester (0 = highest priority)
package speaker_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP,
        COOL
    } state_t;

    typedef struct packed {
        logic [17:0] hp;
        logic [7:0]  beeps;
        logic [15:0] on_ticks;
        logic [15:0] off_ticks;
    } pattern_t;

    localparam pattern_t PAT_ALARM    = '{hp: 18'd12500, beeps: 8'd3, on_ticks: 16'd150, off_ticks: 16'd100};
    localparam pattern_t PAT_OBSTACLE = '{hp: 18'd25000, beeps: 8'd2, on_ticks: 16'd100, off_ticks: 16'd100};
    localparam pattern_t PAT_ACK      = '{hp: 18'd18939, beeps: 8'd1, on_ticks: 16'd50,  off_ticks: 16'd0};
    localparam pattern_t PAT_CHIME    = '{hp: 18'd47778, beeps: 8'd1, on_ticks: 16'd300, off_ticks: 16'd0};

    localparam pattern_t [NUM_REQ-1:0] PATTERNS = {PAT_CHIME, PAT_ACK, PAT_OBSTACLE, PAT_ALARM};

endpackage

// File: rtl/speaker_arbiter_tone_gen.sv
// tone_gen: square-wave generator for the piezo.
//   clk, rst    - clock, synchronous active-high reset
//   en          - run the tone; when low the counter clears and out drops
//   half_period - cycles per output half-period
//   out         - square wave, period 2*half_period cycles
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [17:0] half_period,
    output logic        out
);

    logic [17:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            out <= 1'b0;
        // >= rather than == so a shorter half-period taken mid-tone
        // (preemption while sounding) wraps at once instead of running away
        end else if (cnt >= half_period - 18'd1) begin
            cnt <= '0;
            out <= ~out;
        end else begin
            cnt <= cnt + 18'd1;
        end
    end

endmodule

// File: rtl/speaker_arbiter.sv
// speaker_arbiter: fixed-priority, preemptive owner of the single piezo.
//   clk, rst - clock, synchronous active-high reset
//   req      - level requests, bit 0 highest priority
//   grant    - one-hot current owner, zero when idle or cooling down
//   busy     - owner present or cooldown running
//   done     - one-cycle pulse in the last cycle of a completed pattern
//   soundOn  - tone currently sounding
//   pizo     - square wave to the piezo
module speaker_arbiter
    import speaker_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int HP_SHIFT = 0,
    parameter int COOLDOWN = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic       soundOn,
    output logic       pizo
);

    localparam logic [15:0] DIV_M1     = 16'(TICK_DIV - 1);
    localparam logic [15:0] COOL_TICKS = 16'(COOLDOWN);

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  beeps_q, beeps_d;
    logic [15:0] presc_q, ticks_q, target;
    logic [1:0]  winner;
    logic [3:0]  higher;
    logic        restart, tick_end, preempt, owned;
    pattern_t    pat;

    assign pat = PATTERNS[owner_q];

    // lowest set index wins
    always_comb begin
        winner = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) winner = 2'(i);
    end

    assign owned   = (state_q == TONE) || (state_q == GAP);
    assign higher  = req & 4'((4'd1 << owner_q) - 4'd1);
    assign preempt = owned && (|higher);

    always_comb begin
        case (state_q)
            TONE:    target = pat.on_ticks;
            GAP:     target = pat.off_ticks;
            COOL:    target = COOL_TICKS;
            default: target = 16'd0;
        endcase
    end

    // true in the final cycle of the current state's duration
    assign tick_end = (presc_q == DIV_M1) && (ticks_q == target - 16'd1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beeps_d = beeps_q;
        restart = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = winner;
                    beeps_d = PATTERNS[winner].beeps;
                    state_d = TONE;
                    restart = 1'b1;
                end
            end
            TONE, GAP: begin
                // preemption outranks completion: no done for a loser
                if (preempt) begin
                    owner_d = winner;
                    beeps_d = PATTERNS[winner].beeps;
                    state_d = TONE;
                    restart = 1'b1;
                end else if (tick_end) begin
                    restart = 1'b1;
                    if (state_q == GAP) begin
                        state_d = TONE;
                    end else begin
                        beeps_d = beeps_q - 8'd1;
                        if (beeps_q == 8'd1) begin
                            done    = 1'b1;
                            state_d = COOL;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            COOL: begin
                if (tick_end) begin
                    state_d = IDLE;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            beeps_q <= 8'd0;
            presc_q <= 16'd0;
            ticks_q <= 16'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beeps_q <= beeps_d;
            if (restart || state_q == IDLE) begin
                presc_q <= 16'd0;
                ticks_q <= 16'd0;
            end else if (presc_q == DIV_M1) begin
                presc_q <= 16'd0;
                ticks_q <= ticks_q + 16'd1;
            end else begin
                presc_q <= presc_q + 16'd1;
            end
        end
    end

    assign grant   = owned ? 4'(4'd1 << owner_q) : 4'd0;
    assign busy    = owned || (state_q == COOL);
    assign soundOn = (state_q == TONE);

    tone_gen u_tone (
        .clk        (clk),
        .rst        (rst),
        .en         (soundOn),
        .half_period(pat.hp >> HP_SHIFT),
        .out        (pizo)
    );

endmodule
